// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds FSM state encoding and a reference full-subtractor function.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Returns {bout, d} for a - b - bin.
  function automatic logic [1:0] full_sub(
    input logic a,
    input logic b,
    input logic bin
  );
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// master: start/A/B out, status/result in; slave: the reverse.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borr;

  modport master (
    output start, A, B,
    input  ready, busy, done, Diff, Borr
  );

  modport slave (
    input  start, A, B,
    output ready, busy, done, Diff, Borr
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// Combinational one-bit full subtractor built from two half subtractors.
// Ports: a, b, bin in; d (difference), bout (borrow out) out.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule

module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .a    (a),
    .b    (b),
    .d    (d1),
    .bout (b1)
  );

  half_subtractor u_hs1 (
    .a    (d1),
    .b    (bin),
    .d    (d),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: Diff = A - B, Borr = (A < B), LSB first.
// Ports: clk, rst (sync, active high), bus (slave: start/A/B in, ready/busy/done/Diff/Borr out).
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int              CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_nxt;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             borr_q;
  logic             d;
  logic             bout;
  logic             last;

  full_subtractor_bit u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  assign last = (cnt == LAST);

  // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  always_comb begin
    d_nxt            = d_sh >> 1;
    d_nxt[WIDTH-1]   = d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE,
      ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_d = last ? ST_DONE : ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      d_sh    <= '0;
      cnt     <= '0;
      br      <= 1'b0;
      diff_q  <= '0;
      borr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE,
        ST_DONE: begin
          if (bus.start) begin
            a_sh <= bus.A;
            b_sh <= bus.B;
            d_sh <= '0;
            cnt  <= '0;
            br   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_nxt;
          br   <= bout;
          cnt  <= cnt + CNT_W'(1);
          // Results are only exposed on the completion edge.
          if (last) begin
            diff_q <= d_nxt;
            borr_q <= bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state_q != ST_SHIFT);
  assign bus.busy  = (state_q == ST_SHIFT);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.Diff  = diff_q;
  assign bus.Borr  = borr_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Checks reset, results, busy-start rejection, abort, back-to-back and random pairs.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) i8 ();
  serial_subtractor_if #(.WIDTH(1)) i1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (i8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (i1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] diff, output logic borr,
                      output int nbusy);
    int cyc;
    i8.A     = a;
    i8.B     = b;
    i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    nbusy    = 0;
    cyc      = 0;
    while (i8.done !== 1'b1 && cyc < 40) begin
      if (i8.busy === 1'b1) nbusy++;
      tick();
      cyc++;
    end
    chk("run8_done_seen", {31'd0, i8.done}, 32'd1);
    diff = i8.Diff;
    borr = i8.Borr;
  endtask

  task automatic run1(input logic a, input logic b,
                      output logic diff, output logic borr);
    int cyc;
    i1.A     = a;
    i1.B     = b;
    i1.start = 1'b1;
    tick();
    i1.start = 1'b0;
    cyc      = 0;
    while (i1.done !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("run1_latency", cyc, 32'd1);
    diff = i1.Diff;
    borr = i1.Borr;
  endtask

  logic [7:0] rd;
  logic       rb;
  logic       r1d;
  logic       r1b;
  int         nb;
  int         n;
  int         dcnt;
  logic [7:0] dcap;
  logic [7:0] pa [4];
  logic [7:0] pb [4];
  logic [7:0] pd [4];
  logic       pbr [4];
  logic [7:0] ra;
  logic [7:0] rbv;
  logic [1:0] exp1 [4];

  initial begin
    rst      = 1'b1;
    i8.start = 1'b0;
    i8.A     = '0;
    i8.B     = '0;
    i1.start = 1'b0;
    i1.A     = '0;
    i1.B     = '0;
    tick();
    tick();

    // Reset state
    chk("rst_ready", {31'd0, i8.ready}, 32'd1);
    chk("rst_busy",  {31'd0, i8.busy},  32'd0);
    chk("rst_done",  {31'd0, i8.done},  32'd0);
    chk("rst_diff",  {24'd0, i8.Diff},  32'd0);
    chk("rst_borr",  {31'd0, i8.Borr},  32'd0);
    rst = 1'b0;
    tick();

    // 1: 5A - 3C
    run8(8'h5A, 8'h3C, rd, rb, nb);
    chk("t1_diff", {24'd0, rd}, 32'h1E);
    chk("t1_borr", {31'd0, rb}, 32'd0);
    chk("t1_busy_cycles", nb, 32'd8);
    chk("t1_ready_in_done", {31'd0, i8.ready}, 32'd1);
    tick();
    chk("t1_done_one_cycle", {31'd0, i8.done}, 32'd0);

    // 2: underflow and equal operands
    run8(8'h00, 8'h01, rd, rb, nb);
    chk("t2a_diff", {24'd0, rd}, 32'hFF);
    chk("t2a_borr", {31'd0, rb}, 32'd1);
    run8(8'hA5, 8'hA5, rd, rb, nb);
    chk("t2b_diff", {24'd0, rd}, 32'h00);
    chk("t2b_borr", {31'd0, rb}, 32'd0);
    tick();

    // 3: start while busy is ignored
    i8.A     = 8'h10;
    i8.B     = 8'h01;
    i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    tick();
    tick();
    chk("t3_ready_busy", {31'd0, i8.ready}, 32'd0);
    chk("t3_diff_held", {24'd0, i8.Diff}, 32'h00);
    i8.A     = 8'hFF;
    i8.B     = 8'h00;
    i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    dcnt = 0;
    dcap = '0;
    for (int i = 0; i < 25; i++) begin
      if (i8.done === 1'b1) begin
        dcnt++;
        dcap = i8.Diff;
      end
      tick();
    end
    chk("t3_done_count", dcnt, 32'd1);
    chk("t3_diff", {24'd0, dcap}, 32'h0F);
    chk("t3_borr", {31'd0, i8.Borr}, 32'd0);

    // 4: reset mid-operation
    i8.A     = 8'h33;
    i8.B     = 8'h11;
    i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t4_ready", {31'd0, i8.ready}, 32'd1);
    chk("t4_busy",  {31'd0, i8.busy},  32'd0);
    chk("t4_diff",  {24'd0, i8.Diff},  32'd0);
    chk("t4_borr",  {31'd0, i8.Borr},  32'd0);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (i8.done === 1'b1) dcnt++;
      tick();
    end
    chk("t4_no_done", dcnt, 32'd0);

    // 5: back-to-back with start held high
    pa[0] = 8'h80; pb[0] = 8'h01; pd[0] = 8'h7F; pbr[0] = 1'b0;
    pa[1] = 8'h01; pb[1] = 8'h02; pd[1] = 8'hFF; pbr[1] = 1'b1;
    pa[2] = 8'hFF; pb[2] = 8'hFF; pd[2] = 8'h00; pbr[2] = 1'b0;
    pa[3] = 8'h37; pb[3] = 8'h73; pd[3] = 8'hC4; pbr[3] = 1'b1;
    i8.A     = pa[0];
    i8.B     = pb[0];
    i8.start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (i8.done !== 1'b1 && n < 40);
      chk($sformatf("t5_period_%0d", k), n, (k == 0) ? 32'd8 : 32'd9);
      chk($sformatf("t5_diff_%0d", k), {24'd0, i8.Diff}, {24'd0, pd[k]});
      chk($sformatf("t5_borr_%0d", k), {31'd0, i8.Borr}, {31'd0, pbr[k]});
      if (k < 3) begin
        i8.A = pa[k+1];
        i8.B = pb[k+1];
      end else begin
        i8.start = 1'b0;
      end
    end
    tick();

    // 6: WIDTH=1 truth table; {Diff,Borr} for AB = 00,01,10,11
    exp1[0] = 2'b00;
    exp1[1] = 2'b11;
    exp1[2] = 2'b10;
    exp1[3] = 2'b00;
    for (int v = 0; v < 4; v++) begin
      run1(v[1], v[0], r1d, r1b);
      chk($sformatf("t6_w1_ab%0d", v), {30'd0, r1d, r1b}, {30'd0, exp1[v]});
    end

    // 6b: random pairs at WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rbv = 8'($urandom_range(0, 255));
      run8(ra, rbv, rd, rb, nb);
      chk("t6_rand_diff", {24'd0, rd}, {24'd0, 8'(ra - rbv)});
      chk("t6_rand_borr", {31'd0, rb}, {31'd0, (ra < rbv)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
